// File: rtl/led_bin_display_pkg.sv
// Shared types and constants for the binary-to-LED display driver.
package led_bin_display_pkg;

    typedef logic [3:0] bin_nibble_t;

    // Bit position of each weighted LED within the displayed nibble.
    localparam int unsigned LED1_BIT = 0;
    localparam int unsigned LED2_BIT = 1;
    localparam int unsigned LED4_BIT = 2;
    localparam int unsigned LED8_BIT = 3;

    // Default PWM frame: half brightness over a 16-cycle frame.
    localparam int unsigned DEFAULT_PWM_PERIOD = 16;
    localparam int unsigned DEFAULT_PWM_DUTY   = 8;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM frame counter with duty compare; pwm_on_o is high for the
// first PWM_DUTY cycles of every PWM_PERIOD-cycle frame.
module led_pwm_gen
    import led_bin_display_pkg::*;
#(
    parameter int unsigned PWM_PERIOD = DEFAULT_PWM_PERIOD,
    parameter int unsigned PWM_DUTY   = DEFAULT_PWM_DUTY
) (
    input  logic clock_i,
    input  logic reset_i,
    output logic pwm_on_o
);

    localparam int unsigned CntW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PWM_PERIOD - 1);

    logic [CntW-1:0] pwm_cnt_q, pwm_cnt_d;

    // Next count: wrap to zero at the end of the frame.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + CntW'(1);
        if (pwm_cnt_q == CntMax) begin
            pwm_cnt_d = '0;
        end
        // Widened compare so PWM_DUTY == PWM_PERIOD gives an always-on gate.
        pwm_on_o = (32'(pwm_cnt_q) < PWM_DUTY);
    end

    // Frame counter register, cleared by reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

endmodule

// File: rtl/led_bin_display.sv
// Registered 4-bit binary-to-LED driver (weights 1, 2, 4, 8).
// Optional uniform dimming is enabled by defining LED_BIN_DISPLAY_PWM_EN.
// The output register holds physical pin levels, so every LED comes straight
// from a flop with polarity already applied.
module led_bin_display
    import led_bin_display_pkg::*;
#(
    parameter int unsigned PWM_PERIOD      = DEFAULT_PWM_PERIOD,
    parameter int unsigned PWM_DUTY        = DEFAULT_PWM_DUTY,
    parameter bit          LED_ACTIVE_HIGH = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] binNumber,
    output logic       led1,
    output logic       led2,
    output logic       led4,
    output logic       led8
);

    // Pin level of an unlit LED; lit LEDs drive the complement.
    localparam bin_nibble_t OffLevel = LED_ACTIVE_HIGH ? 4'b0000 : 4'b1111;

    logic        pwm_on;
    bin_nibble_t led_q, led_d;

`ifdef LED_BIN_DISPLAY_PWM_EN
    led_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .PWM_DUTY   (PWM_DUTY)
    ) u_pwm_gen (
        .clock_i  (clock),
        .reset_i  (reset),
        .pwm_on_o (pwm_on)
    );
`else
    assign pwm_on = 1'b1;

    // PWM settings have no effect without the dimming stage.
    logic unused_pwm_cfg;
    assign unused_pwm_cfg = ^{PWM_PERIOD, PWM_DUTY};
`endif

    // Gate the value with the PWM window, then apply pin polarity per bit.
    always_comb begin
        led_d = (bin_nibble_t'(binNumber) & {4{pwm_on}}) ^ OffLevel;
    end

    // LED output register; reset blanks all LEDs.
    always_ff @(posedge clock) begin
        if (reset) begin
            led_q <= OffLevel;
        end else begin
            led_q <= led_d;
        end
    end

    assign led1 = led_q[LED1_BIT];
    assign led2 = led_q[LED2_BIT];
    assign led4 = led_q[LED4_BIT];
    assign led8 = led_q[LED8_BIT];

endmodule

// File: tb/tb_led_bin_display.sv
// Scoreboard bench for led_bin_display: an active-high and an active-low
// instance share the stimulus; a reference model pushes the expected lit
// pattern at each edge and independent monitors pop and compare.
module tb_led_bin_display;

    localparam int unsigned Period = 16;
    localparam int unsigned Duty   = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] binNumber = 4'b0000;
    logic       h1, h2, h4, h8;
    logic       l1, l2, l4, l8;

    led_bin_display #(
        .PWM_PERIOD      (Period),
        .PWM_DUTY        (Duty),
        .LED_ACTIVE_HIGH (1'b1)
    ) u_dut_hi (
        .clock     (clock),
        .reset     (reset),
        .binNumber (binNumber),
        .led1      (h1),
        .led2      (h2),
        .led4      (h4),
        .led8      (h8)
    );

    led_bin_display #(
        .PWM_PERIOD      (Period),
        .PWM_DUTY        (Duty),
        .LED_ACTIVE_HIGH (1'b0)
    ) u_dut_lo (
        .clock     (clock),
        .reset     (reset),
        .binNumber (binNumber),
        .led1      (l1),
        .led2      (l2),
        .led4      (l4),
        .led8      (l8)
    );

    always #10 clock = ~clock;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    logic [3:0] exp_q[$];
    logic [3:0] cur_exp;
    bit         have_cur = 1'b0;

    // Reference model: lit pattern = value gated by frame position, where the
    // frame position is the number of loads since reset, modulo the period.
    bit          started = 1'b0;
    int unsigned frame_pos = 0;

    always @(posedge clock) begin
        logic [3:0] e;
        if (reset) begin
            started   = 1'b1;
            frame_pos = 0;
            exp_q.push_back(4'b0000);
        end else if (started) begin
            e = binNumber;
`ifdef LED_BIN_DISPLAY_PWM_EN
            if (frame_pos >= Duty) e = 4'b0000;
            frame_pos = (frame_pos + 1) % Period;
`endif
            exp_q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [3:0] exp_lit);
        logic [3:0] hi_act;
        logic [3:0] lo_act;
        hi_act = {h8, h4, h2, h1};
        lo_act = {l8, l4, l2, l1};
        vectors++;
        if (hi_act !== exp_lit) begin
            errors++;
            $display("FAIL %s active-high: got %b expected %b at %0t", name, hi_act, exp_lit,
                     $time);
        end
        vectors++;
        if (lo_act !== ~exp_lit) begin
            errors++;
            $display("FAIL %s active-low: got %b expected %b at %0t", name, lo_act, ~exp_lit,
                     $time);
        end
    endtask

    // Monitor: after each edge the LEDs present a new registered value.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            cur_exp  = exp_q.pop_front();
            have_cur = 1'b1;
            check("post_edge", cur_exp);
        end
    end

    // Monitor: late in the low phase, after mid-cycle input changes, the
    // LEDs must still hold the value loaded at the previous edge.
    always @(negedge clock) begin
        #7;
        if (have_cur) check("mid_cycle_hold", cur_exp);
    end

    // One cycle of stimulus: settle the value, then glitch it briefly and
    // restore it, all between rising edges.
    task automatic step(input logic [3:0] val, input logic rst, input logic [3:0] glitch);
        @(negedge clock);
        #1;
        binNumber = val;
        reset     = rst;
        if (glitch != 4'b0000) begin
            #2 binNumber = val ^ glitch;
            #3 binNumber = val;
        end
    endtask

    initial begin
        // Reset held for 3 edges with all inputs high.
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 4'b0000);
        step(4'b1111, 1'b0, 4'b0000);
        step(4'b1111, 1'b0, 4'b0000);

        // Sweep all codes, 5 cycles each, with a bit-3 pulse mid-cycle.
        for (int v = 0; v < 16; v++) begin
            for (int c = 0; c < 5; c++) step(4'(v), 1'b0, 4'b1000);
        end

        // 0011 -> 0100 with mid-cycle change.
        step(4'b0011, 1'b0, 4'b0000);
        step(4'b0011, 1'b0, 4'b0111);
        step(4'b0100, 1'b0, 4'b0000);

        // Reset mid-run for one edge with 0110 held.
        step(4'b0110, 1'b0, 4'b0000);
        step(4'b0110, 1'b1, 4'b0000);
        for (int c = 0; c < 3; c++) step(4'b0110, 1'b0, 4'b0000);

        // Randomized traffic with occasional resets and glitches.
        for (int c = 0; c < 400; c++) begin
            step(4'($urandom_range(15)), ($urandom_range(24) == 0),
                 ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'b0000);
        end

        step(4'b0000, 1'b0, 4'b0000);
        @(posedge clock);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
